regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file for the pipelined RISC-V core. It provides two combinational read ports and one synchronous write port, with x0 hard-wired to zero and optional write-to-read bypass. Each register carries a pending-write counter (scoreboard), so decode can detect RAW hazards on outstanding writes and stall. It sits between decode (reads and issue) and write-back (writes and retire).

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers including x0; power of two, minimum 2.
ADDR_W, $clog2(NREGS), register address width (derived; not overridden).
CNT_W, 2, width of each per-register pending-write counter; maximum outstanding writes per register is 2^CNT_W-1.
BYPASS, 1, when 1 a read of the register being written in the same cycle returns writedata.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
rs1_addr  in  ADDR_W  read port 1 address.
rs2_addr  in  ADDR_W  read port 2 address.
rs1  out  XLEN  read port 1 data.
rs2  out  XLEN  read port 2 data.
rs1_busy  out  1  register rs1_addr has at least one pending write.
rs2_busy  out  1  register rs2_addr has at least one pending write.
issue_valid  in  1  decode issues an instruction that will write issue_rd.
issue_rd  in  ADDR_W  destination register of the issued instruction.
issue_ready  out  1  scoreboard can accept an issue to issue_rd.
regwrite  in  1  write-back write enable; also retires one pending write.
writereg_addr  in  ADDR_W  write-back destination.
writedata  in  XLEN  write-back data.

Behaviour:
- Reset: clk and rst are the only clock and reset. The reset is synchronous and active-high. On a rising edge with rst=1, all registers go to 0 and all pending counters go to 0. After reset, rs1/rs2 read 0, rs1_busy/rs2_busy are 0 and issue_ready is 1. rst overrides any concurrent write or issue.
- Write:
  - On a rising edge with regwrite=1 and writereg_addr!=0, the register at writereg_addr captures writedata.
  - Writes to x0 are discarded.
- Read:
  - Reads are purely combinational, with zero latency.
  - Address 0 always returns 0.
  - If BYPASS=1, regwrite=1, writereg_addr==rsN_addr and the address is not 0, then rsN=writedata.
  - If BYPASS=0, the old value is returned and the new value is visible the cycle after the write.
- Scoreboard counter per register r (r!=0):
  - inc = issue_valid & issue_ready & issue_rd==r.
  - dec = regwrite & writereg_addr==r & cnt[r]!=0.
  - inc&~dec: cnt+1. dec&~inc: cnt-1. Both or neither: cnt unchanged.
  - A write-back to a register with cnt=0 (untracked write) performs the write and leaves cnt at 0. It never underflows.
- x0 counter is constant 0. Issue to x0 is always accepted and has no scoreboard effect.
- issue_ready = 0 only when issue_rd!=0 and cnt[issue_rd]==2^CNT_W-1 and the same cycle has no dec on issue_rd; otherwise 1. Counters never wrap.
- rsN_busy = (cnt[rsN_addr]!=0), combinational.
  - Exception for BYPASS=1: if the same cycle has a dec on rsN_addr taking cnt from 1 to 0, rsN_busy=0, because the bypassed data is final.
- Read-port hazard output reflects counter state before the clock edge, apart from the bypass exception above.
- issue_ready may depend combinationally on issue_valid-independent inputs only (issue_rd, regwrite, writereg_addr); there is no loop through issue_valid.

Decomposition:
- Package riscv_rf_pkg:
  - XLEN default, NREGS default and ADDR_W derivation.
  - Constant REG_ZERO=0.
- Sub-module rf_pending_cnt: one CNT_W saturating up/down counter with inc, dec, rst and outputs cnt, nonzero and full. Instantiate NREGS-1 copies in a generate loop; x0 is tied off.

Test Plan:
1. Reset, then read all 32 addresses -> every rs1/rs2 reads 0x00000000; rs1_busy=rs2_busy=0; issue_ready=1.
2. Write x5=0xDEADBEEF, read x5 the next cycle -> rs1=0xDEADBEEF. Then write x0=0x12345678 -> reading x0 still returns 0.
3. BYPASS=1: in one cycle, regwrite x7=0xA5A5A5A5 while rs2_addr=7 -> rs2=0xA5A5A5A5 in that same cycle. BYPASS=0: the same stimulus gives the old value, and 0xA5A5A5A5 the next cycle.
4. Scoreboard, first sequence:
   - issue_rd=3 -> rs1_busy=1 on rs1_addr=3.
   - Write-back x3 -> busy 0 the next cycle.
   - Issue and write-back on x3 in the same cycle -> count unchanged.
5. Scoreboard, second sequence:
   - Issue x9 three times (CNT_W=2) -> issue_ready=0 for issue_rd=9, while issue to x10 is still ready.
   - Write-back x9 -> issue_ready=1.
   - Untracked write-back to x11 with cnt=0 -> cnt stays 0.
6. Reset mid-operation: with x4=0x55 and cnt[4]=2, assert rst together with regwrite x4=0x77 -> after the edge x4=0, cnt[4]=0, and issue_ready=1.

Source files
------------

// File: rtl/riscv_rf_pkg.sv
// riscv_rf_pkg
// Shared constants for the integer register file and its scoreboard.
//   XLEN_DEFAULT  - default data width of one architectural register
//   NREGS_DEFAULT - default number of architectural registers (x0 included)
//   REG_ZERO      - index of the hard-wired zero register
//   rf_addr_w()   - register address width derived from a register count
package riscv_rf_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;

    // The address width is always derived from the register count and is
    // never chosen independently.
    function automatic int rf_addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/rf_pending_cnt.sv
// rf_pending_cnt
// Pending-write counter for one architectural register.
// It saturates in both directions and never wraps.
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset, clears the count
//   inc     in   one more write to this register has been issued
//   dec     in   one outstanding write to this register has retired
//   cnt     out  current number of outstanding writes
//   nonzero out  at least one write is outstanding
//   full    out  counter is at its maximum value
module rf_pending_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero,
    output logic             full
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // When inc and dec arrive together they cancel out.
    // The full and nonzero guards keep the count from wrapping, even if a
    // caller misbehaves.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && nonzero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = |cnt_q;
    assign full    = &cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Integer register file with two combinational read ports and one
// synchronous write port. x0 is hard-wired to zero. A same-cycle
// write-to-read bypass is optional. Each register has a pending-write
// scoreboard, which decode uses to detect RAW hazards.
//   clk, rst                        clock and synchronous active-high reset
//   rs1_addr/rs2_addr -> rs1/rs2    combinational read ports
//   rs1_busy/rs2_busy               read register has outstanding writes
//   issue_valid/issue_rd            decode issues a writer of issue_rd
//   issue_ready                     scoreboard can accept that issue
//   regwrite/writereg_addr/writedata
//                                   write-back port; also retires a write
import riscv_rf_pkg::*;

module regfile_sb #(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = NREGS_DEFAULT,
    parameter  int CNT_W  = 2,
    parameter  int BYPASS = 1,
    localparam int ADDR_W = rf_addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1,
    output logic [XLEN-1:0]   rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] writereg_addr,
    input  logic [XLEN-1:0]   writedata
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [CNT_W-1:0] cnt_all [NREGS];
    logic [NREGS-1:0] nonzero_v;
    logic [NREGS-1:0] full_v;

    // A write-back can only change registers other than x0.
    // x0 is forced back to zero so that it never holds another value.
    always_comb begin
        regs_d = regs_q;
        if (regwrite && writereg_addr != ZERO_ADDR) begin
            regs_d[writereg_addr] = writedata;
        end
        regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 has no scoreboard. Its entries are tied off so that indexed
    // lookups with address 0 report "not pending".
    assign cnt_all[REG_ZERO]   = '0;
    assign nonzero_v[REG_ZERO] = 1'b0;
    assign full_v[REG_ZERO]    = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        logic inc;
        logic dec;
        assign inc = issue_valid & issue_ready & (issue_rd == ADDR_W'(r));
        // A write-back to an untracked register still writes data.
        // It does not retire anything.
        assign dec = regwrite & (writereg_addr == ADDR_W'(r)) & nonzero_v[r];
        rf_pending_cnt #(
            .CNT_W   (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc),
            .dec     (dec),
            .cnt     (cnt_all[r]),
            .nonzero (nonzero_v[r]),
            .full    (full_v[r])
        );
    end

    // A full counter can still take an issue when a retire to the same
    // register happens in the same cycle, because the two cancel out.
    // This does not depend on issue_valid, so there is no combinational
    // loop back into decode.
    always_comb begin
        issue_ready = 1'b1;
        if (issue_rd != ZERO_ADDR && full_v[issue_rd]
            && !(regwrite && writereg_addr == issue_rd)) begin
            issue_ready = 1'b0;
        end
    end

    // Read ports and hazard flags.
    // With the bypass enabled, a register whose final pending write
    // retires this cycle is reported as not busy: the bypassed data is
    // already the final value. This exception does not apply if a new
    // issue to the same register arrives in the same cycle.
    always_comb begin
        rs1      = regs_q[rs1_addr];
        rs2      = regs_q[rs2_addr];
        rs1_busy = nonzero_v[rs1_addr];
        rs2_busy = nonzero_v[rs2_addr];
        if (BYPASS != 0 && regwrite && writereg_addr == rs1_addr) begin
            rs1 = writedata;
            if (cnt_all[rs1_addr] == CNT_W'(1)
                && !(issue_valid && issue_ready && issue_rd == rs1_addr)) begin
                rs1_busy = 1'b0;
            end
        end
        if (BYPASS != 0 && regwrite && writereg_addr == rs2_addr) begin
            rs2 = writedata;
            if (cnt_all[rs2_addr] == CNT_W'(1)
                && !(issue_valid && issue_ready && issue_rd == rs2_addr)) begin
                rs2_busy = 1'b0;
            end
        end
        if (rs1_addr == ZERO_ADDR) begin
            rs1      = '0;
            rs1_busy = 1'b0;
        end
        if (rs2_addr == ZERO_ADDR) begin
            rs2      = '0;
            rs2_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Drives two register files from the same inputs: one with the bypass
// enabled and one without. Every output is compared against a reference
// model built from plain arrays of register values and pending counts.
module tb_regfile_sb;

    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, writereg_addr;
    logic        issue_valid, regwrite;
    logic [31:0] writedata;

    logic [31:0] rs1_b, rs2_b, rs1_n, rs2_n;
    logic        rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n;
    logic        ready_b, ready_n;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];

    always #5 clk = ~clk;

    regfile_sb #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1(rs1_b), .rs2(rs2_b),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(ready_b),
        .regwrite(regwrite), .writereg_addr(writereg_addr), .writedata(writedata)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1(rs1_n), .rs2(rs2_n),
        .rs1_busy(rs1_busy_n), .rs2_busy(rs2_busy_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(ready_n),
        .regwrite(regwrite), .writereg_addr(writereg_addr), .writedata(writedata)
    );

    // Reference model

    function automatic bit exp_ready();
        return !(issue_rd != 0 && m_cnt[issue_rd] == CMAX
                 && !(regwrite && writereg_addr == issue_rd));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && regwrite && writereg_addr == a) return writedata;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && regwrite && writereg_addr == a && m_cnt[a] == 1
            && !(issue_valid && exp_ready() && issue_rd == a)) return 1'b0;
        return m_cnt[a] != 0;
    endfunction

    task automatic model_update();
        bit dec_ok, inc_ok;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 32'h0;
                m_cnt[i] = 0;
            end
        end else begin
            dec_ok = regwrite && writereg_addr != 0 && m_cnt[writereg_addr] > 0;
            inc_ok = issue_valid && exp_ready() && issue_rd != 0;
            if (regwrite && writereg_addr != 0) m_reg[writereg_addr] = writedata;
            if (dec_ok) m_cnt[writereg_addr] -= 1;
            if (inc_ok) m_cnt[issue_rd] += 1;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; issue_valid = 1'b0; regwrite = 1'b0;
        issue_rd = '0; writereg_addr = '0; writedata = '0;
    endtask

    // Scenarios

    task automatic test_reset();
        idle();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'hx;
            m_cnt[i] = 0;
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            checks++;
            if (rs1_b !== 32'h0 || rs2_b !== 32'h0 || rs1_n !== 32'h0 || rs2_n !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_read addr=%0d got rs1=%h rs2=%h expected 0", i, rs1_b, rs2_b);
            end
            checks++;
            if ({rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n} !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL reset_busy addr=%0d got %b expected 0000", i,
                         {rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n});
            end
        end
        checks++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready got %b/%b expected 1", ready_b, ready_n);
        end
    endtask

    task automatic test_write_read();
        idle();
        regwrite = 1'b1; writereg_addr = 5'd5; writedata = 32'hDEADBEEF;
        step();
        idle();
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_b !== 32'hDEADBEEF || rs1_n !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL write_x5 got %h/%h expected deadbeef", rs1_b, rs1_n);
        end
        regwrite = 1'b1; writereg_addr = 5'd0; writedata = 32'h12345678;
        rs1_addr = 5'd0;
        #1;
        checks++;
        if (rs1_b !== 32'h0) begin
            failures++;
            $display("[TB] FAIL x0_bypass got %h expected 0", rs1_b);
        end
        step();
        idle();
        #1;
        checks++;
        if (rs1_b !== 32'h0 || rs1_n !== 32'h0) begin
            failures++;
            $display("[TB] FAIL write_x0 got %h/%h expected 0", rs1_b, rs1_n);
        end
    endtask

    task automatic test_bypass();
        idle();
        rs2_addr = 5'd7;
        regwrite = 1'b1; writereg_addr = 5'd7; writedata = 32'hA5A5A5A5;
        #1;
        checks++;
        if (rs2_b !== 32'hA5A5A5A5) begin
            failures++;
            $display("[TB] FAIL bypass_on got %h expected a5a5a5a5", rs2_b);
        end
        checks++;
        if (rs2_n !== m_reg[7]) begin
            failures++;
            $display("[TB] FAIL bypass_off_old got %h expected %h", rs2_n, m_reg[7]);
        end
        step();
        idle();
        #1;
        checks++;
        if (rs2_n !== 32'hA5A5A5A5) begin
            failures++;
            $display("[TB] FAIL bypass_off_next got %h expected a5a5a5a5", rs2_n);
        end
    endtask

    task automatic test_scoreboard_basic();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        idle();
        rs1_addr = 5'd3;
        #1;
        checks++;
        if (rs1_busy_b !== 1'b1 || rs1_busy_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sb_issue_busy got %b/%b expected 1", rs1_busy_b, rs1_busy_n);
        end
        // Final retire: the bypass copy is not busy, the other copy still is.
        regwrite = 1'b1; writereg_addr = 5'd3; writedata = 32'h33;
        #1;
        checks++;
        if (rs1_busy_b !== 1'b0 || rs1_busy_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sb_retire_same_cycle got %b/%b expected 0/1", rs1_busy_b, rs1_busy_n);
        end
        step();
        idle();
        rs1_addr = 5'd3;
        #1;
        checks++;
        if (rs1_busy_b !== 1'b0 || rs1_busy_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sb_retire_next got %b/%b expected 0", rs1_busy_b, rs1_busy_n);
        end
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        // Issue and retire together: the count stays at 1.
        issue_valid = 1'b1; issue_rd = 5'd3;
        regwrite = 1'b1; writereg_addr = 5'd3; writedata = 32'h44;
        #1;
        checks++;
        if (rs1_busy_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sb_both_same_cycle got %b expected 1", rs1_busy_b);
        end
        step();
        idle();
        rs1_addr = 5'd3;
        #1;
        checks++;
        if (rs1_busy_b !== 1'b1 || rs1_busy_n !== 1'b1 || m_cnt[3] != 1) begin
            failures++;
            $display("[TB] FAIL sb_both_unchanged got %b/%b expected 1", rs1_busy_b, rs1_busy_n);
        end
        regwrite = 1'b1; writereg_addr = 5'd3; writedata = 32'h55;
        step();
        idle();
    endtask

    task automatic test_saturation();
        idle();
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_rd = 5'd9;
            step();
        end
        // This issue must be refused while the counter is full.
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        checks++;
        if (ready_b !== 1'b0 || ready_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_full_ready got %b/%b expected 0", ready_b, ready_n);
        end
        step();
        issue_valid = 1'b0; issue_rd = 5'd10;
        #1;
        checks++;
        if (ready_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_other_ready got %b expected 1", ready_b);
        end
        issue_rd = 5'd9;
        regwrite = 1'b1; writereg_addr = 5'd9; writedata = 32'h99;
        #1;
        checks++;
        if (ready_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_retire_comb_ready got %b expected 1", ready_b);
        end
        step();
        idle();
        issue_rd = 5'd9;
        #1;
        checks++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_after_retire got %b/%b expected 1", ready_b, ready_n);
        end
        regwrite = 1'b1; writereg_addr = 5'd11; writedata = 32'h1111;
        step();
        idle();
        rs2_addr = 5'd11;
        #1;
        checks++;
        if (rs2_busy_b !== 1'b0 || rs2_busy_n !== 1'b0 || rs2_b !== 32'h1111) begin
            failures++;
            $display("[TB] FAIL untracked_wb got busy=%b data=%h expected 0/1111", rs2_busy_b, rs2_b);
        end
        for (int k = 0; k < 2; k++) begin
            regwrite = 1'b1; writereg_addr = 5'd9; writedata = 32'h9;
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        regwrite = 1'b1; writereg_addr = 5'd4; writedata = 32'h55;
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            issue_valid = 1'b1; issue_rd = 5'd4;
            step();
        end
        idle();
        rs1_addr = 5'd4;
        #1;
        checks++;
        if (rs1_b !== 32'h55 || rs1_busy_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_pre got %h/%b expected 55/1", rs1_b, rs1_busy_b);
        end
        rst = 1'b1; regwrite = 1'b1; writereg_addr = 5'd4; writedata = 32'h77;
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        idle();
        rs1_addr = 5'd4; issue_rd = 5'd4;
        #1;
        checks++;
        if (rs1_b !== 32'h0 || rs1_n !== 32'h0 || rs1_busy_b !== 1'b0 || ready_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_post got %h/%b/%b expected 0/0/1", rs1_b, rs1_busy_b, ready_b);
        end
    endtask

    task automatic test_random();
        logic [4:0] hot;
        for (int c = 0; c < 400; c++) begin
            // Use a few hot registers so that the scoreboard gets exercised.
            hot         = 5'($urandom_range(0, 5));
            rst         = ($urandom_range(0, 59) == 0);
            issue_valid = $urandom_range(0, 1) != 0;
            issue_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : hot;
            regwrite    = $urandom_range(0, 2) != 0;
            writereg_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            writedata   = $urandom;
            rs1_addr    = ($urandom_range(0, 1) != 0) ? writereg_addr : 5'($urandom_range(0, 5));
            rs2_addr    = 5'($urandom);
            #1;
            checks++;
            if (rs1_b !== exp_rd(rs1_addr, 1'b1) || rs2_b !== exp_rd(rs2_addr, 1'b1)) begin
                failures++;
                $display("[TB] FAIL rand_read_byp cyc=%0d got %h/%h expected %h/%h", c,
                         rs1_b, rs2_b, exp_rd(rs1_addr, 1'b1), exp_rd(rs2_addr, 1'b1));
            end
            checks++;
            if (rs1_n !== exp_rd(rs1_addr, 1'b0) || rs2_n !== exp_rd(rs2_addr, 1'b0)) begin
                failures++;
                $display("[TB] FAIL rand_read_nobyp cyc=%0d got %h/%h expected %h/%h", c,
                         rs1_n, rs2_n, exp_rd(rs1_addr, 1'b0), exp_rd(rs2_addr, 1'b0));
            end
            checks++;
            if (rs1_busy_b !== exp_busy(rs1_addr, 1'b1) || rs2_busy_b !== exp_busy(rs2_addr, 1'b1)
                || rs1_busy_n !== exp_busy(rs1_addr, 1'b0) || rs2_busy_n !== exp_busy(rs2_addr, 1'b0)) begin
                failures++;
                $display("[TB] FAIL rand_busy cyc=%0d got %b%b%b%b expected %b%b%b%b", c,
                         rs1_busy_b, rs2_busy_b, rs1_busy_n, rs2_busy_n,
                         exp_busy(rs1_addr, 1'b1), exp_busy(rs2_addr, 1'b1),
                         exp_busy(rs1_addr, 1'b0), exp_busy(rs2_addr, 1'b0));
            end
            checks++;
            if (ready_b !== exp_ready() || ready_n !== exp_ready()) begin
                failures++;
                $display("[TB] FAIL rand_ready cyc=%0d got %b/%b expected %b", c, ready_b, ready_n, exp_ready());
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        rs1_addr = '0;
        rs2_addr = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard_basic();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
